// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer and its 4-bit slice.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  // Slice function codes. Arithmetic codes chain the carry; logic codes
  // ignore it and report cout=0, overflow=0; SHL shifts carry in at bit 0.
  localparam logic [3:0] ALU_OP_ADD  = 4'b0000; // A + B + Cin
  localparam logic [3:0] ALU_OP_SUB  = 4'b0001; // A + ~B + Cin
  localparam logic [3:0] ALU_OP_INC  = 4'b0010; // A + Cin
  localparam logic [3:0] ALU_OP_DEC  = 4'b0011; // A + 4'hF + Cin
  localparam logic [3:0] ALU_OP_AND  = 4'b0100;
  localparam logic [3:0] ALU_OP_OR   = 4'b0101;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0110;
  localparam logic [3:0] ALU_OP_NOR  = 4'b0111;
  localparam logic [3:0] ALU_OP_NAND = 4'b1000;
  localparam logic [3:0] ALU_OP_XNOR = 4'b1001;
  localparam logic [3:0] ALU_OP_NOTA = 4'b1010;
  localparam logic [3:0] ALU_OP_PASB = 4'b1011;
  localparam logic [3:0] ALU_OP_ZERO = 4'b1100;
  localparam logic [3:0] ALU_OP_ONES = 4'b1101;
  localparam logic [3:0] ALU_OP_SHL  = 4'b1110; // {A[2:0],Cin}, Cout = A[3]
  localparam logic [3:0] ALU_OP_RSUB = 4'b1111; // B + ~A + Cin

endpackage

// File: rtl/alu_nibble_sequencer_slice.sv
// Combinational 4-bit ALU slice: result, carry out and signed overflow.
module alu_nibble_sequencer_slice
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic [3:0]         s_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] r_o,
  output logic               co_o,
  output logic               ov_o
);

  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W:0]   sum;
  logic               arith;

  // Select addends for arithmetic codes, or form the logic result directly.
  always_comb begin
    x     = a_i;
    y     = '0;
    sum   = '0;
    arith = 1'b0;
    r_o   = '0;
    co_o  = 1'b0;
    ov_o  = 1'b0;
    case (s_i)
      ALU_OP_ADD:  begin y = b_i;   arith = 1'b1; end
      ALU_OP_SUB:  begin y = ~b_i;  arith = 1'b1; end
      ALU_OP_INC:  begin y = '0;    arith = 1'b1; end
      ALU_OP_DEC:  begin y = '1;    arith = 1'b1; end
      ALU_OP_RSUB: begin x = b_i; y = ~a_i; arith = 1'b1; end
      ALU_OP_AND:  r_o = a_i & b_i;
      ALU_OP_OR:   r_o = a_i | b_i;
      ALU_OP_XOR:  r_o = a_i ^ b_i;
      ALU_OP_NOR:  r_o = ~(a_i | b_i);
      ALU_OP_NAND: r_o = ~(a_i & b_i);
      ALU_OP_XNOR: r_o = ~(a_i ^ b_i);
      ALU_OP_NOTA: r_o = ~a_i;
      ALU_OP_PASB: r_o = b_i;
      ALU_OP_ZERO: r_o = '0;
      ALU_OP_ONES: r_o = '1;
      ALU_OP_SHL:  begin r_o = {a_i[2:0], ci_i}; co_o = a_i[3]; end
      default:     r_o = '0;
    endcase
    if (arith) begin
      sum  = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, ci_i};
      r_o  = sum[SLICE_W-1:0];
      co_o = sum[SLICE_W];
      ov_o = (x[SLICE_W-1] == y[SLICE_W-1]) && (sum[SLICE_W-1] != x[SLICE_W-1]);
    end
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial ALU: one 4-bit slice time-multiplexed over NIBBLES cycles,
// least significant nibble first, with the carry chained through a register.
// Optional zero flag output enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic [3:0]             req_s,
  input  logic                   req_cin,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [4*NIBBLES-1:0]   resp_result,
  output logic                   resp_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                   resp_zero,
`endif
  output logic                   resp_overflow
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [3:0]    s_q, s_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ov_q, ov_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic          zero_q, zero_d;
`endif

  logic [SLICE_W-1:0] nib_a, nib_b, slice_r;
  logic               slice_co, slice_ov;

  assign nib_a = a_q[k_q*SLICE_W +: SLICE_W];
  assign nib_b = b_q[k_q*SLICE_W +: SLICE_W];

  alu_nibble_sequencer_slice u_slice (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .s_i  (s_q),
    .ci_i (carry_q),
    .r_o  (slice_r),
    .co_o (slice_co),
    .ov_o (slice_ov)
  );

  // Next-state, operand latching, per-nibble capture and handshake outputs.
  // The carry register is seeded with req_cin so nibble 0 sees it directly.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    res_d      = res_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    ov_d       = ov_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d     = zero_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          s_d     = req_s;
          carry_d = req_cin;
          k_d     = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d[k_q*SLICE_W +: SLICE_W] = slice_r;
        carry_d = slice_co;
        if (k_q == K_LAST) begin
          cout_d  = slice_co;
          ov_d    = slice_ov;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero_d  = (res_d == '0);
`endif
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so nothing stale escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign resp_result   = res_q;
  assign resp_cout     = cout_q;
  assign resp_overflow = ov_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign resp_zero     = zero_q;
`endif

endmodule

// File: doc/alu_nibble_sequencer.md
ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices processed per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_a  input  W  operand A.
REQ-007 req_b  input  W  operand B.
REQ-008 req_s  input  4  ALU function select, passed unchanged to every slice.
REQ-009 req_cin  input  1  carry into nibble 0.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 resp_result  output  W  assembled result.
REQ-013 resp_cout  output  1  carry out of the most significant nibble.
REQ-014 resp_overflow  output  1  overflow flag of the most significant nibble.
REQ-015 resp_zero  output  1  resp_result == 0; present only when ALU_SEQ_ZERO_FLAG_EN is defined.

Function
REQ-016 FSM states IDLE, EXEC, DONE. Transitions: IDLE->EXEC on req_valid&&req_ready; EXEC->DONE after the nibble NIBBLES-1 capture; DONE->IDLE on resp_valid&&resp_ready.
REQ-017 req_ready = 1 only in IDLE; resp_valid = 1 only in DONE.
REQ-018 On acceptance, latch req_a, req_b, req_s and req_cin; later changes to the req_* inputs do not affect the operation in flight.
REQ-019 EXEC lasts exactly NIBBLES cycles, with a nibble index k = 0..NIBBLES-1. In cycle k, drive the ALU slice with A[4k+3:4k], B[4k+3:4k] and the latched S.
REQ-020 Slice carry-in for k=0 is the latched req_cin. For k>0 it is the registered Cout of nibble k-1. The carry is chained for every S code; the slice decides whether carry is meaningful.
REQ-021 At the end of cycle k, register the slice result into resp_result[4k+3:4k] and register the slice Cout.
REQ-022 At k = NIBBLES-1, register the slice Cout into resp_cout and the slice overflow into resp_overflow.
REQ-023 Latency: resp_valid rises exactly NIBBLES cycles after the acceptance edge; 4 cycles at the default.
REQ-024 In DONE, resp_result, resp_cout and resp_overflow hold stable until the response handshake completes. Back-pressure of any length is tolerated.
REQ-025 req_valid asserted outside IDLE is ignored and has no side effect; the requester holds it until req_ready.
REQ-026 Nibble index wrap: k returns to 0 on the EXEC->DONE transition; k never exceeds NIBBLES-1.
REQ-027 Throughput: one operation per NIBBLES+2 cycles at most, with resp_ready held at 1.

Reset
REQ-028 rst sampled high at a rising edge: state=IDLE, k=0, and all latched operands, resp_result, resp_cout, resp_overflow and the carry register = 0.
REQ-029 After such a reset edge: req_ready=1 and resp_valid=0.
REQ-030 rst during EXEC or DONE aborts the operation; no response is produced for it.
REQ-031 A request presented in the first cycle after rst deasserts is accepted normally.

Configuration
REQ-032 Macro ALU_SEQ_ZERO_FLAG_EN defined: port resp_zero exists. It is registered together with the final nibble, valid whenever resp_valid=1, and 0 after reset.
REQ-033 Macro ALU_SEQ_ZERO_FLAG_EN undefined: no resp_zero port and no zero-detect logic; all other behaviour is identical.

Structure
REQ-034 Shared package alu_pkg holds:
- state enum (IDLE, EXEC, DONE);
- slice width constant SLICE_W = 4;
- function-select constant ALU_OP_ADD = 4'b0000 (A+B+Cin).
REQ-035 Exactly one sub-module: the existing 4-bit ALU slice, instance name u_slice, reused once and time-multiplexed across nibbles (not replicated).

Verification
REQ-036 Add with ripple: A=16'h00FF, B=16'h0001, S=ALU_OP_ADD, cin=0. Required: result=16'h0100, cout=0, overflow=0, resp_valid high exactly 4 cycles after acceptance.
REQ-037 Carry out: A=16'hFFFF, B=16'h0001, cin=0, S=ALU_OP_ADD. Required: result=16'h0000, cout=1, overflow=0; resp_zero=1 when ALU_SEQ_ZERO_FLAG_EN is defined.
REQ-038 Signed overflow: A=16'h7FFF, B=16'h0001, cin=0, S=ALU_OP_ADD. Required: result=16'h8000, cout=0, overflow=1.
REQ-039 Back-pressure: hold resp_ready=0 for 10 cycles after resp_valid, and toggle req_a/req_valid during that time. Required: response stable, req_ready=0 throughout, next request accepted only after the handshake.
REQ-040 Reset mid-operation: assert rst in EXEC cycle k=2. Required next cycle: req_ready=1, resp_valid=0, resp_result=0; no stale response appears afterwards.
REQ-041 All 16 S codes with random operands: each result nibble matches a per-nibble model of the slice with the chained carry.
